// File: rtl/radar_rx_pkg.sv
// rtl/radar_rx_pkg.sv - shared types and constants for the radar receive path
package radar_rx_pkg;

  // Width of frame, sample and drop counters
  localparam int CNT_W = 16;

  // Default header tag written at the start of each frame
  localparam logic [15:0] HDR_MAGIC_DEF = 16'hA5A5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    STREAM  = 2'd2,
    WAITLOW = 2'd3
  } wr_state_t;

endpackage

// File: rtl/sat_cnt_v.sv
// rtl/sat_cnt_v.sv - 16-bit saturating increment counter with synchronous active-low clear
module sat_cnt_v
  import radar_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count up on inc, hold at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/radar_frame_writer.sv
// rtl/radar_frame_writer.sv - packs I/Q samples of a receive window into FIFO frames; header word under FRAME_HEADER_EN
module radar_frame_writer
  import radar_rx_pkg::*;
#(
  parameter int          SWIDTH    = 16,
  parameter int          MAXSAMP   = 4096,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic                wclk_i,
  input  logic                rst,
  input  logic                win_i,
  input  logic                sample_valid_i,
  input  logic [SWIDTH-1:0]   i_i,
  input  logic [SWIDTH-1:0]   q_i,
  input  logic                fifo_full_i,
  output logic                fifo_wen_o,
  output logic [2*SWIDTH-1:0] fifo_data_o,
  output logic                frame_done_o,
  output logic [15:0]         nsamp_o,
  output logic [15:0]         drop_o,
  output logic                busy_o
);

  localparam logic [SWIDTH-1:0] MAGIC    = SWIDTH'(HDR_MAGIC);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(MAXSAMP - 1);

`ifdef FRAME_HEADER_EN
  localparam wr_state_t FIRST_ST = HDR;
`else
  localparam wr_state_t FIRST_ST = STREAM;
`endif

  wr_state_t        state;
  logic             win_q;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] samp_cnt;

  logic win_rise;
  logic accept;
  logic drop_inc;

  assign win_rise = win_i & ~win_q;
  assign accept   = (state == STREAM) & win_i & sample_valid_i;
  // Samples arriving while the header is pending are lost and must be counted
  assign drop_inc = (accept & fifo_full_i) |
                    ((state == HDR) & win_i & sample_valid_i);
  assign busy_o   = (state != IDLE);

  // Previous win_i for rising-edge detection
  always_ff @(posedge wclk_i) begin
    if (!rst) begin
      win_q <= 1'b0;
    end else begin
      win_q <= win_i;
    end
  end

  // Frame FSM with registered FIFO, done and sample-count outputs
  always_ff @(posedge wclk_i) begin
    if (!rst) begin
      state        <= IDLE;
      fifo_wen_o   <= 1'b0;
      fifo_data_o  <= '0;
      frame_done_o <= 1'b0;
      nsamp_o      <= '0;
      frame_cnt    <= '0;
      samp_cnt     <= '0;
    end else begin
      fifo_wen_o   <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (win_rise) begin
            samp_cnt <= '0;
            state    <= FIRST_ST;
          end
        end
        HDR: begin
          // A window that closes before the header goes out is not a frame
          if (!win_i) begin
            state <= IDLE;
          end else if (!fifo_full_i) begin
            fifo_wen_o  <= 1'b1;
            fifo_data_o <= {MAGIC, SWIDTH'(frame_cnt)};
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (!win_i) begin
            // A sample coinciding with the window close is discarded uncounted
            frame_done_o <= 1'b1;
            nsamp_o      <= samp_cnt;
            frame_cnt    <= frame_cnt + CNT_W'(1);
            state        <= IDLE;
          end else if (sample_valid_i && !fifo_full_i) begin
            fifo_wen_o  <= 1'b1;
            fifo_data_o <= {i_i, q_i};
            samp_cnt    <= samp_cnt + CNT_W'(1);
            if (samp_cnt == LAST_IDX) begin
              frame_done_o <= 1'b1;
              nsamp_o      <= samp_cnt + CNT_W'(1);
              frame_cnt    <= frame_cnt + CNT_W'(1);
              state        <= WAITLOW;
            end
          end
        end
        WAITLOW: begin
          if (!win_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_cnt_v u_drop_cnt (
    .clk   (wclk_i),
    .rst   (rst),
    .inc   (drop_inc),
    .count (drop_o)
  );

endmodule

// File: tb/tb_radar_frame_writer.sv
// tb/tb_radar_frame_writer.sv - directed self-checking bench for radar_frame_writer
module tb_radar_frame_writer;

`ifdef FRAME_HEADER_EN
  localparam int H         = 1;
  localparam int DROP_BASE = 4;
`else
  localparam int H         = 0;
  localparam int DROP_BASE = 3;
`endif

  logic        wclk_i = 1'b0;
  logic        rst;
  logic        win_i;
  logic        sample_valid_i;
  logic [15:0] i_i;
  logic [15:0] q_i;
  logic        fifo_full_i;

  logic        a_wen, b_wen;
  logic [31:0] a_data, b_data;
  logic        a_done, b_done;
  logic [15:0] a_nsamp, b_nsamp;
  logic [15:0] a_drop, b_drop;
  logic        a_busy, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wq[$];
  logic [31:0] wq8[$];
  int          done_a      = 0;
  int          done_b      = 0;
  int          wr_at_done8 = -1;
  logic        full_prev   = 1'b0;

  radar_frame_writer dut (
    .wclk_i         (wclk_i),
    .rst            (rst),
    .win_i          (win_i),
    .sample_valid_i (sample_valid_i),
    .i_i            (i_i),
    .q_i            (q_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wen_o     (a_wen),
    .fifo_data_o    (a_data),
    .frame_done_o   (a_done),
    .nsamp_o        (a_nsamp),
    .drop_o         (a_drop),
    .busy_o         (a_busy)
  );

  radar_frame_writer #(.MAXSAMP(8)) dut8 (
    .wclk_i         (wclk_i),
    .rst            (rst),
    .win_i          (win_i),
    .sample_valid_i (sample_valid_i),
    .i_i            (i_i),
    .q_i            (q_i),
    .fifo_full_i    (fifo_full_i),
    .fifo_wen_o     (b_wen),
    .fifo_data_o    (b_data),
    .frame_done_o   (b_done),
    .nsamp_o        (b_nsamp),
    .drop_o         (b_drop),
    .busy_o         (b_busy)
  );

  always #5 wclk_i = ~wclk_i;

  // Record FIFO writes and done pulses; a write must never follow a full cycle
  always @(negedge wclk_i) begin
    if (a_wen) begin
      wq.push_back(a_data);
      n_tests++;
      assert (full_prev === 1'b0) else begin
        n_fail++;
        $error("FAIL wen_after_full observed full_prev=%b expected=0", full_prev);
      end
    end
    if (b_wen) wq8.push_back(b_data);
    if (a_done) done_a++;
    if (b_done) begin
      done_b++;
      wr_at_done8 = wq8.size();
    end
    full_prev = fifo_full_i;
  end

  task automatic tick();
    @(posedge wclk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] smp(input int k);
    logic [15:0] iv;
    logic [15:0] qv;
    iv = 16'(32'h1000 + k);
    qv = 16'(32'h2000 + k);
    return {iv, qv};
  endfunction

  task automatic set_sample(input int k);
    i_i = 16'(32'h1000 + k);
    q_i = 16'(32'h2000 + k);
  endtask

  // Open window, n samples (full during [flo,fhi]), close with optional coincident sample
  task automatic send_frame(input int n, input int flo, input int fhi, input logic fall_valid);
    win_i = 1'b1; sample_valid_i = 1'b0; fifo_full_i = 1'b0;
    tick(); tick();
    for (int k = 1; k <= n; k++) begin
      sample_valid_i = 1'b1;
      set_sample(k);
      fifo_full_i = (k >= flo) && (k <= fhi);
      tick();
    end
    win_i = 1'b0; fifo_full_i = 1'b0;
    sample_valid_i = fall_valid;
    set_sample(n + 1);
    tick();
    sample_valid_i = 1'b0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b0; win_i = 1'b0; sample_valid_i = 1'b0; fifo_full_i = 1'b0;
    i_i = '0; q_i = '0;
    tick(); tick(); tick();

    // Reset state
    check("rst_wen",   32'(a_wen),   32'h0);
    check("rst_data",  a_data,       32'h0);
    check("rst_done",  32'(a_done),  32'h0);
    check("rst_nsamp", 32'(a_nsamp), 32'h0);
    check("rst_drop",  32'(a_drop),  32'h0);
    check("rst_busy",  32'(a_busy),  32'h0);
    rst = 1'b1;
    tick();

    // Frame 1: 10 clean samples, window closes with a valid sample
    wq.delete();
    send_frame(10, 99, 0, 1'b1);
    check("f1_count", wq.size(), 32'(H + 10));
`ifdef FRAME_HEADER_EN
    check("f1_header", wq[0], 32'hA5A5_0000);
`endif
    check("f1_first", wq[H],     smp(1));
    check("f1_last",  wq[H + 9], smp(10));
    check("f1_done",  done_a,    32'd1);
    check("f1_nsamp", 32'(a_nsamp), 32'd10);
    check("f1_drop",  32'(a_drop),  32'd0);
    check("f1_busy",  32'(a_busy),  32'd0);

    // Frame 2: FIFO full during samples 4..6
    wq.delete();
    send_frame(10, 4, 6, 1'b0);
    check("f2_count", wq.size(), 32'(H + 7));
`ifdef FRAME_HEADER_EN
    check("f2_header", wq[0], 32'hA5A5_0001);
`endif
    check("f2_s3",    wq[H + 2], smp(3));
    check("f2_s7",    wq[H + 3], smp(7));
    check("f2_done",  done_a,    32'd2);
    check("f2_nsamp", 32'(a_nsamp), 32'd7);
    check("f2_drop",  32'(a_drop),  32'd3);

    // Frame 3: 12 samples against the MAXSAMP=8 instance
    wq.delete(); wq8.delete();
    win_i = 1'b1; sample_valid_i = 1'b0; fifo_full_i = 1'b0;
    tick(); tick();
    for (int k = 1; k <= 12; k++) begin
      sample_valid_i = 1'b1;
      set_sample(k);
      tick();
    end
    sample_valid_i = 1'b0;
    tick();
    check("lim_count",   wq8.size(),  32'(H + 8));
`ifdef FRAME_HEADER_EN
    check("lim_header",  wq8[0], 32'hA5A5_0002);
`endif
    check("lim_s8",      wq8[H + 7],  smp(8));
    check("lim_done_at", wr_at_done8, 32'(H + 8));
    check("lim_done",    done_b,      32'd3);
    check("lim_nsamp",   32'(b_nsamp), 32'd8);
    check("lim_waitlow", 32'(b_busy),  32'd1);
    check("lim_drop",    32'(b_drop),  32'd3);
    win_i = 1'b0;
    tick(); tick();
    check("lim_idle",    32'(b_busy),  32'd0);
    check("lim_done2",   done_b,       32'd3);
    check("big_nsamp",   32'(a_nsamp), 32'd12);
    check("big_done",    done_a,       32'd3);

`ifdef FRAME_HEADER_EN
    // Sample dropped while header is blocked, then window closes in HDR
    wq.delete();
    win_i = 1'b1; sample_valid_i = 1'b1; fifo_full_i = 1'b1;
    tick(); tick();
    win_i = 1'b0; sample_valid_i = 1'b0; fifo_full_i = 1'b0;
    tick(); tick();
    check("hdr_drop",   32'(a_drop), 32'd4);
    check("hdr_nowr",   wq.size(),   32'd0);
    check("hdr_nodone", done_a,      32'd3);
    check("hdr_busy",   32'(a_busy), 32'd0);
`endif

    // Reset asserted at sample 5 of a frame
    wq.delete();
    win_i = 1'b1; sample_valid_i = 1'b0; fifo_full_i = 1'b0;
    tick(); tick();
    for (int k = 1; k <= 4; k++) begin
      sample_valid_i = 1'b1;
      set_sample(k);
      tick();
    end
    check("pre_rst_drop", 32'(a_drop), 32'(DROP_BASE));
    set_sample(5);
    rst = 1'b0;
    tick();
    check("mid_rst_wen",   32'(a_wen),   32'h0);
    check("mid_rst_data",  a_data,       32'h0);
    check("mid_rst_nsamp", 32'(a_nsamp), 32'h0);
    check("mid_rst_drop",  32'(a_drop),  32'h0);
    check("mid_rst_busy",  32'(a_busy),  32'h0);
    win_i = 1'b0; sample_valid_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_nodone", done_a, 32'd3);
    wq.delete();
    send_frame(2, 99, 0, 1'b0);
`ifdef FRAME_HEADER_EN
    check("post_rst_header", wq[0], 32'hA5A5_0000);
`endif
    check("post_rst_first", wq[H],       smp(1));
    check("post_rst_nsamp", 32'(a_nsamp), 32'd2);
    check("post_rst_done",  done_a,       32'd4);

    // Drop counter saturation
    wq.delete();
    send_frame(65540, 1, 65540, 1'b0);
    check("sat_drop",   32'(a_drop),  32'h0000_FFFF);
    check("sat_drop8",  32'(b_drop),  32'h0000_FFFF);
    check("sat_nsamp",  32'(a_nsamp), 32'd0);
    check("sat_writes", wq.size(),    32'(H));
    check("sat_done",   done_a,       32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/radar_frame_writer.md
RADAR_FRAME_WRITER -- requirements
Module: radar_frame_writer

Interface
REQ-001 SHALL have parameter SWIDTH, default 16: I and Q sample width.
REQ-002 SHALL have parameter MAXSAMP, default 4096: maximum samples written per frame.
REQ-003 SHALL have parameter HDR_MAGIC, default 16'hA5A5: header tag, taken as its low SWIDTH bits.
REQ-004 SHALL have port wclk_i, input, 1 bit: clock, shared with the FIFO write side.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-low, on clock wclk_i.
REQ-006 SHALL have port win_i, input, 1 bit: receive-window gate.
REQ-007 SHALL have port sample_valid_i, input, 1 bit: i_i and q_i are valid this cycle.
REQ-008 SHALL have ports i_i and q_i, input, SWIDTH bits each: in-phase and quadrature samples.
REQ-009 SHALL have port fifo_full_i, input, 1 bit: FIFO full flag, same cycle.
REQ-010 SHALL have port fifo_wen_o, output, 1 bit: FIFO write enable.
REQ-011 SHALL have port fifo_data_o, output, 2*SWIDTH bits: FIFO write data.
REQ-012 SHALL have port frame_done_o, output, 1 bit: one-cycle end-of-frame pulse.
REQ-013 SHALL have port nsamp_o, output, 16 bits: samples written in the last completed frame.
REQ-014 SHALL have port drop_o, output, 16 bits: samples dropped, saturating, cumulative since reset.
REQ-015 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, HDR, STREAM and WAITLOW.
REQ-017 IDLE SHALL move to HDR (or to STREAM when the header is compiled out) on a win_i rising edge, registered against the previous win_i.
REQ-018 HDR SHALL write the word {HDR_MAGIC, frame_cnt[SWIDTH-1:0]} on the first cycle with fifo_full_i=0, then move to STREAM.
REQ-019 A sample SHALL be accepted when state=STREAM, win_i=1 and sample_valid_i=1.
REQ-020 An accepted sample with fifo_full_i=0 SHALL be written as fifo_data_o={i_i,q_i} with fifo_wen_o high in the next cycle, giving a latency of 1.
REQ-021 An accepted sample with fifo_full_i=1 SHALL NOT be written and SHALL increment drop_o.
REQ-022 A sample presented while in HDR SHALL be dropped and counted in drop_o.
REQ-023 drop_o SHALL saturate at 16'hFFFF.
REQ-024 fifo_wen_o SHALL never assert in a cycle following fifo_full_i=1.
REQ-025 The frame sample count SHALL count written samples only; the header word is excluded.
REQ-026 STREAM SHALL end when win_i=0, moving to IDLE.
REQ-027 STREAM SHALL also end after the write of the MAXSAMP-th sample, moving to WAITLOW.
REQ-028 If win_i falls in the same cycle as a valid sample, that sample SHALL be dropped silently and not counted.
REQ-029 On STREAM exit, frame_done_o SHALL pulse for 1 cycle and nsamp_o SHALL load the frame count in the same cycle.
REQ-030 On STREAM exit, frame_cnt SHALL increment, wrapping at 2^16.
REQ-031 WAITLOW SHALL ignore samples (no drop count) and return to IDLE when win_i=0.
REQ-032 A win_i rising edge outside IDLE SHALL be ignored.
REQ-033 win_i falling in HDR SHALL move to IDLE without writing the header and without pulsing frame_done_o.

Reset
REQ-034 While rst=0, the block SHALL clear state to IDLE and clear all outputs, frame_cnt, the frame sample count and the win_i history register to 0.
REQ-035 Reset mid-frame SHALL abort the frame with no frame_done_o pulse and no partial nsamp_o update.

Configuration
REQ-036 Macro FRAME_HEADER_EN SHALL control the header feature.
REQ-037 With FRAME_HEADER_EN defined, the HDR state and the header word SHALL be present.
REQ-038 With FRAME_HEADER_EN undefined, IDLE SHALL go directly to STREAM, no header SHALL be written, and frame_cnt SHALL still count.

Structure
REQ-039 Package radar_rx_pkg SHALL hold the FSM state typedef, HDR_MAGIC default and the 16-bit counter width constant.
REQ-040 Sub-module sat_cnt_v (16-bit saturating increment counter, synchronous active-low clear) SHALL implement drop_o.

Verification
REQ-041 Header, no full: SWIDTH=16, FRAME_HEADER_EN defined, win_i high for 10 valid samples -> first write 32'hA5A5_0000, then 10 sample writes, frame_done_o pulse, nsamp_o=10.
REQ-042 Full mid-frame: fifo_full_i high during samples 4..6 of 10 -> 7 samples written, drop_o=3, nsamp_o=7.
REQ-043 MAXSAMP limit: MAXSAMP=8, window of 12 valid samples -> 8 writes, frame_done_o after the 8th, state WAITLOW until win_i=0, drop_o unchanged.
REQ-044 Back-to-back frames: second frame -> header 32'hA5A5_0001.
REQ-045 Header off: FRAME_HEADER_EN undefined -> first write is {i_i,q_i} of sample 1.
REQ-046 Reset mid-frame: rst low at sample 5 -> all outputs 0, no frame_done_o; next window header carries frame_cnt=0.
